// File: rtl/flash_audio_sequencer.sv
// Walks the flash audio region over an Avalon-MM read master, emitting one 16-bit sample per tick.
// Each fetched 32-bit word supplies two samples; direction selects which half comes first.
module flash_audio_sequencer #(
  parameter int unsigned          ADDR_W     = 23,
  parameter logic [ADDR_W-1:0]    START_ADDR = 23'h000000,
  parameter logic [ADDR_W-1:0]    END_ADDR   = 23'h07FFFF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_tick,
  input  logic                pause,
  input  logic                play_forward,
  input  logic                restart,
  output logic                flash_read,
  output logic [ADDR_W-1:0]   flash_address,
  input  logic                flash_waitrequest,
  input  logic                flash_readdatavalid,
  input  logic [31:0]         flash_readdata,
  output logic signed [15:0]  audio_sample,
  output logic                sample_valid
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_half;
  logic                r_dir;
  logic                r_discard;
  logic [31:0]         r_word_buf;
  logic signed [15:0]  r_audio;
  logic                r_valid;
  logic [ADDR_W-1:0]   w_step;
  logic [ADDR_W-1:0]   w_reload;

  assign w_reload = play_forward ? START_ADDR : END_ADDR;

  always_comb begin
    if (play_forward) w_step = (r_addr == END_ADDR)   ? START_ADDR : r_addr + 1'b1;
    else              w_step = (r_addr == START_ADDR) ? END_ADDR   : r_addr - 1'b1;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (sample_tick && !pause && !restart && !r_half) w_next = S_REQ;
      S_REQ:  if (!flash_waitrequest) w_next = S_WAIT;
      S_WAIT: if (flash_readdatavalid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // r_dir remembers which half was emitted first, so the second half is
  // always the other one even if play_forward flips between the two ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr     <= START_ADDR;
      r_half     <= 1'b0;
      r_dir      <= 1'b1;
      r_discard  <= 1'b0;
      r_word_buf <= '0;
      r_audio    <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (restart) begin
            r_addr <= w_reload;
            r_half <= 1'b0;
          end else if (sample_tick && !pause && r_half) begin
            r_audio <= r_dir ? r_word_buf[31:16] : r_word_buf[15:0];
            r_valid <= 1'b1;
            r_half  <= 1'b0;
            r_addr  <= w_step;
          end
        end
        S_REQ: begin
          if (restart) r_discard <= 1'b1;
        end
        S_WAIT: begin
          if (flash_readdatavalid) begin
            r_word_buf <= flash_readdata;
            r_discard  <= 1'b0;
            if (r_discard || restart) begin
              r_addr <= w_reload;
              r_half <= 1'b0;
            end else begin
              r_audio <= play_forward ? flash_readdata[15:0] : flash_readdata[31:16];
              r_valid <= 1'b1;
              r_half  <= 1'b1;
              r_dir   <= play_forward;
            end
          end else if (restart) begin
            r_discard <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign flash_read    = (r_state == S_REQ);
  assign flash_address = r_addr;
  assign audio_sample  = r_audio;
  assign sample_valid  = r_valid;

endmodule

// File: tb/tb_flash_audio_sequencer.sv
// Directed bench for flash_audio_sequencer with a behavioural Avalon flash slave.
module tb_flash_audio_sequencer;

  localparam logic [22:0] START_A = 23'h000000;
  localparam logic [22:0] END_A   = 23'h07FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic        pause = 1'b0;
  logic        play_forward = 1'b1;
  logic        restart = 1'b0;
  logic        flash_read;
  logic [22:0] flash_address;
  logic        flash_waitrequest = 1'b0;
  logic        flash_readdatavalid = 1'b0;
  logic [31:0] flash_readdata = '0;
  logic [15:0] audio_sample;
  logic        sample_valid;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] mem [int unsigned];
  int unsigned ws_left = 0;
  int unsigned pend = 0;
  logic [22:0] pend_addr = '0;
  logic [22:0] held_addr = '0;
  logic [22:0] last_rd = '0;
  int unsigned n_reads = 0;
  int unsigned n_valid = 0;
  int unsigned stall_cycles = 0;
  int unsigned stall_viol = 0;
  logic [15:0] last_sample = '0;
  int unsigned r0, v0;
  logic [15:0] s0;

  always #5 clk = ~clk;

  flash_audio_sequencer #(.ADDR_W(23), .START_ADDR(START_A), .END_ADDR(END_A)) u_dut (
    .clk                 (clk),
    .reset               (reset),
    .sample_tick         (sample_tick),
    .pause               (pause),
    .play_forward        (play_forward),
    .restart             (restart),
    .flash_read          (flash_read),
    .flash_address       (flash_address),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdatavalid (flash_readdatavalid),
    .flash_readdata      (flash_readdata),
    .audio_sample        (audio_sample),
    .sample_valid        (sample_valid)
  );

  function automatic logic [31:0] rd_word(input logic [22:0] a);
    int unsigned k;
    k = int'(a);
    if (mem.exists(k)) return mem[k];
    return {16'hDEAD, 16'h0000};
  endfunction

  // Flash slave: optional wait states at the start of a read, data two cycles after acceptance.
  always @(negedge clk) begin
    flash_readdatavalid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        flash_readdatavalid = 1'b1;
        flash_readdata      = rd_word(pend_addr);
      end
    end
    if (flash_waitrequest) begin
      stall_cycles++;
      if (!flash_read || flash_address != held_addr) stall_viol++;
    end
    if (flash_read && ws_left > 0) begin
      flash_waitrequest = 1'b1;
      held_addr = flash_address;
      ws_left--;
    end else begin
      flash_waitrequest = 1'b0;
      if (flash_read) begin
        pend_addr = flash_address;
        pend      = 2;
        last_rd   = flash_address;
        n_reads++;
      end
    end
  end

  always @(negedge clk) begin
    if (sample_valid) begin
      n_valid++;
      last_sample = audio_sample;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_tick(input int unsigned settle);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (settle) @(negedge clk);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    repeat (2) @(negedge clk);
    restart = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    mem[32'h0]       = 32'hBBBB_AAAA;
    mem[32'h1]       = 32'h4444_3333;
    mem[32'h7FFFF]   = 32'h2222_1111;
    mem[32'h7FFFE]   = 32'h6666_5555;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_sample", {16'h0, audio_sample}, 32'h0);
    check("rst_valid", {31'h0, sample_valid}, 32'h0);
    check("rst_read", {31'h0, flash_read}, 32'h0);
    check("rst_addr", {9'h0, flash_address}, 32'h0);

    // forward play
    do_tick(10);
    check("fwd_rd0", {9'h0, last_rd}, 32'h0);
    check("fwd_s0", {16'h0, last_sample}, 32'hAAAA);
    check("fwd_nv0", n_valid, 1);
    do_tick(10);
    check("fwd_s1", {16'h0, last_sample}, 32'hBBBB);
    check("fwd_nr1", n_reads, 1);
    do_tick(10);
    check("fwd_rd1", {9'h0, last_rd}, 32'h1);
    check("fwd_s2", {16'h0, last_sample}, 32'h3333);
    check("fwd_nr2", n_reads, 2);

    // reverse play
    play_forward = 1'b0;
    do_restart();
    do_tick(10);
    check("rev_rd0", {9'h0, last_rd}, 32'h7FFFF);
    check("rev_s0", {16'h0, last_sample}, 32'h2222);
    do_tick(10);
    check("rev_s1", {16'h0, last_sample}, 32'h1111);
    do_tick(10);
    check("rev_rd1", {9'h0, last_rd}, 32'h7FFFE);
    check("rev_s2", {16'h0, last_sample}, 32'h6666);

    // forward wrap END -> START after a direction change mid-word
    do_restart();
    do_tick(10);
    play_forward = 1'b1;
    do_tick(10);
    check("wrapf_s", {16'h0, last_sample}, 32'h1111);
    do_tick(10);
    check("wrapf_rd", {9'h0, last_rd}, 32'h0);
    check("wrapf_s2", {16'h0, last_sample}, 32'hAAAA);

    // reverse wrap START -> END
    do_restart();
    do_tick(10);
    play_forward = 1'b0;
    do_tick(10);
    check("wrapr_s", {16'h0, last_sample}, 32'hBBBB);
    do_tick(10);
    check("wrapr_rd", {9'h0, last_rd}, 32'h7FFFF);
    check("wrapr_s2", {16'h0, last_sample}, 32'h2222);

    // wait states
    play_forward = 1'b1;
    do_restart();
    r0 = n_reads; v0 = n_valid; stall_cycles = 0; stall_viol = 0;
    ws_left = 5;
    do_tick(15);
    check("ws_stalls", stall_cycles, 5);
    check("ws_viol", stall_viol, 0);
    check("ws_reads", n_reads - r0, 1);
    check("ws_valid", n_valid - v0, 1);
    check("ws_s", {16'h0, last_sample}, 32'hAAAA);

    // restart while waiting for data
    do_tick(10);
    r0 = n_reads; v0 = n_valid;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    repeat (10) @(negedge clk);
    check("rs_rd", {9'h0, last_rd}, 32'h1);
    check("rs_reads", n_reads - r0, 1);
    check("rs_valid", n_valid - v0, 0);
    do_tick(10);
    check("rs_next_rd", {9'h0, last_rd}, 32'h0);
    check("rs_next_s", {16'h0, last_sample}, 32'hAAAA);

    // pause
    pause = 1'b1;
    r0 = n_reads; v0 = n_valid; s0 = audio_sample;
    for (int i = 0; i < 10; i++) do_tick(4);
    check("pz_reads", n_reads - r0, 0);
    check("pz_valid", n_valid - v0, 0);
    check("pz_hold", {16'h0, audio_sample}, {16'h0, s0});
    pause = 1'b0;
    do_tick(10);
    check("pz_resume", {16'h0, last_sample}, 32'hBBBB);
    check("pz_resume_rd", n_reads - r0, 0);

    // restart and tick together: restart wins
    r0 = n_reads; v0 = n_valid;
    restart = 1'b1;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    restart = 1'b0;
    repeat (10) @(negedge clk);
    check("rt_reads", n_reads - r0, 0);
    check("rt_valid", n_valid - v0, 0);
    do_tick(10);
    check("rt_next_rd", {9'h0, last_rd}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
